// File: rtl/rv_dm_wb_master_if.sv
// ============================================================================
// Module : rv_dm_wb_master_if
// Brief  : Wishbone classic bus bundle between the data-memory master and slave
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rv_dm_wb_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

`default_nettype wire

// File: rtl/rv_dm_wb_master.sv
// ============================================================================
// Module : rv_dm_wb_master
// Brief  : uRV data-memory master; one load/store per Wishbone classic cycle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_dm_wb_master #(
  parameter int g_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  input  logic [2:0]  dm_fun_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  output logic        dm_busy_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_valid_l_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  rv_dm_wb_master_if.master wb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [31:0] C_TMO_LAST = 32'(g_timeout) - 32'd1;

  logic [1:0]  r_state;
  logic [31:0] r_cnt;
  logic        r_we;
  logic [31:0] r_adr;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [31:0] r_data_l;
  logic        r_valid_l;
  logic        r_store_done;
  logic        r_error;

  logic        w_req;
  logic        w_aligned;
  logic [3:0]  w_sel;
  logic [31:0] w_dat;
  logic        w_timeout;

  assign w_req = dm_load_i | dm_store_i;

  // Store takes priority when both requests arrive together; loads always fetch the full word.
  always_comb begin
    w_aligned = 1'b1;
    w_sel     = 4'b1111;
    w_dat     = 32'd0;
    if (dm_store_i) begin
      case (dm_fun_i)
        3'b000: begin
          w_sel = 4'b0001 << dm_addr_i[1:0];
          w_dat = {4{dm_data_s_i[7:0]}};
        end
        3'b001: begin
          w_aligned = ~dm_addr_i[0];
          w_sel     = 4'b0011 << {dm_addr_i[1], 1'b0};
          w_dat     = {2{dm_data_s_i[15:0]}};
        end
        default: begin
          w_aligned = (dm_addr_i[1:0] == 2'b00);
          w_dat     = dm_data_s_i;
        end
      endcase
    end else begin
      case (dm_fun_i[1:0])
        2'b00:   w_aligned = 1'b1;
        2'b01:   w_aligned = ~dm_addr_i[0];
        default: w_aligned = (dm_addr_i[1:0] == 2'b00);
      endcase
    end
  end

  assign w_timeout = (g_timeout != 0) && (r_cnt == C_TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= 32'd0;
      r_we         <= 1'b0;
      r_adr        <= 32'd0;
      r_sel        <= 4'd0;
      r_dat        <= 32'd0;
      r_data_l     <= 32'd0;
      r_valid_l    <= 1'b0;
      r_store_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we  <= dm_store_i;
            r_adr <= {dm_addr_i[31:2], 2'b00};
            r_sel <= w_sel;
            r_dat <= w_dat;
            r_cnt <= 32'd0;
            if (w_aligned) begin
              r_state <= S_BUS;
            end else begin
              r_state      <= S_RESP;
              r_error      <= 1'b1;
              r_valid_l    <= ~dm_store_i;
              r_store_done <= dm_store_i;
              if (!dm_store_i) r_data_l <= 32'd0;
            end
          end
        end
        S_BUS: begin
          r_cnt <= r_cnt + 32'd1;
          // err outranks a simultaneous ack; a failed load returns zero data
          if (wb.wb_err_i || w_timeout || wb.wb_ack_i) begin
            r_state      <= S_RESP;
            r_valid_l    <= ~r_we;
            r_store_done <= r_we;
            r_error      <= wb.wb_err_i | w_timeout;
            if (!r_we) r_data_l <= (wb.wb_err_i || w_timeout) ? 32'd0 : wb.wb_dat_i;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_valid_l    <= 1'b0;
          r_store_done <= 1'b0;
          r_error      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobe is decoded straight from the state register so async reset drops it at once.
  assign wb.wb_cyc_o = (r_state == S_BUS);
  assign wb.wb_stb_o = (r_state == S_BUS);
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_sel_o = r_sel;
  assign wb.wb_dat_o = r_dat;

  assign dm_busy_o       = (r_state != S_IDLE);
  assign dm_data_l_o     = r_data_l;
  assign dm_valid_l_o    = r_valid_l;
  assign dm_store_done_o = r_store_done;
  assign dm_error_o      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_rv_dm_wb_master.sv
// ============================================================================
// Module : tb_rv_dm_wb_master
// Brief  : Directed self-checking bench for rv_dm_wb_master
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_dm_wb_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // DUT A: default timeout
  logic        a_load, a_store;
  logic [2:0]  a_fun;
  logic [31:0] a_addr, a_ds;
  logic        a_busy, a_valid, a_sdone, a_err;
  logic [31:0] a_dl;
  rv_dm_wb_master_if bus_a ();

  rv_dm_wb_master #(.g_timeout(255)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_load_i(a_load), .dm_store_i(a_store), .dm_fun_i(a_fun),
    .dm_addr_i(a_addr), .dm_data_s_i(a_ds),
    .dm_busy_o(a_busy), .dm_data_l_o(a_dl), .dm_valid_l_o(a_valid),
    .dm_store_done_o(a_sdone), .dm_error_o(a_err),
    .wb(bus_a)
  );

  // DUT B: short timeout, slave never answers
  logic        b_load, b_store;
  logic [2:0]  b_fun;
  logic [31:0] b_addr, b_ds;
  logic        b_busy, b_valid, b_sdone, b_err;
  logic [31:0] b_dl;
  rv_dm_wb_master_if bus_b ();

  rv_dm_wb_master #(.g_timeout(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_load_i(b_load), .dm_store_i(b_store), .dm_fun_i(b_fun),
    .dm_addr_i(b_addr), .dm_data_s_i(b_ds),
    .dm_busy_o(b_busy), .dm_data_l_o(b_dl), .dm_valid_l_o(b_valid),
    .dm_store_done_o(b_sdone), .dm_error_o(b_err),
    .wb(bus_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    n_total++;
    if ({a_busy, bus_a.wb_cyc_o, bus_a.wb_stb_o, a_valid, a_sdone, a_err} !== 6'b0)
      $display("FAIL reset_ctrl got %b exp 000000",
               {a_busy, bus_a.wb_cyc_o, bus_a.wb_stb_o, a_valid, a_sdone, a_err});
    else n_pass++;
    n_total++;
    if ({a_dl, bus_a.wb_adr_o, bus_a.wb_sel_o, bus_a.wb_we_o} !== 69'd0)
      $display("FAIL reset_data got dl=%h adr=%h sel=%b we=%b exp zeros",
               a_dl, bus_a.wb_adr_o, bus_a.wb_sel_o, bus_a.wb_we_o);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_byte;
    a_store = 1'b1; a_fun = 3'b000; a_addr = 32'h103; a_ds = 32'h0000_00A5;
    bus_a.wb_ack_i = 1'b1;
    tick();
    a_store = 1'b0;
    n_total++;
    if ({bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o, a_busy} !== 4'b1111)
      $display("FAIL sb_bus got cyc/stb/we/busy=%b exp 1111",
               {bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o, a_busy});
    else n_pass++;
    n_total++;
    if (bus_a.wb_sel_o !== 4'b1000 || bus_a.wb_dat_o !== 32'hA5A5_A5A5 ||
        bus_a.wb_adr_o !== 32'h100)
      $display("FAIL sb_lanes got sel=%b dat=%h adr=%h exp sel=1000 dat=a5a5a5a5 adr=00000100",
               bus_a.wb_sel_o, bus_a.wb_dat_o, bus_a.wb_adr_o);
    else n_pass++;
    tick();
    bus_a.wb_ack_i = 1'b0;
    n_total++;
    if ({a_sdone, a_valid, a_err, bus_a.wb_cyc_o} !== 4'b1000)
      $display("FAIL sb_resp got done/valid/err/cyc=%b exp 1000",
               {a_sdone, a_valid, a_err, bus_a.wb_cyc_o});
    else n_pass++;
    tick();
    n_total++;
    if ({a_sdone, a_busy} !== 2'b00)
      $display("FAIL sb_idle got done/busy=%b exp 00", {a_sdone, a_busy});
    else n_pass++;
  endtask

  task automatic test_store_half;
    a_store = 1'b1; a_fun = 3'b001; a_addr = 32'h102; a_ds = 32'h1234_BEEF;
    bus_a.wb_ack_i = 1'b1;
    tick();
    a_store = 1'b0;
    n_total++;
    if (bus_a.wb_sel_o !== 4'b1100 || bus_a.wb_dat_o !== 32'hBEEF_BEEF)
      $display("FAIL sh_lanes got sel=%b dat=%h exp sel=1100 dat=beefbeef",
               bus_a.wb_sel_o, bus_a.wb_dat_o);
    else n_pass++;
    tick();
    bus_a.wb_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_load_wait;
    a_load = 1'b1; a_fun = 3'b010; a_addr = 32'h200;
    tick();
    a_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o} !== 3'b110)
        $display("FAIL lw_stb_cycle%0d got cyc/stb/we=%b exp 110", i,
                 {bus_a.wb_cyc_o, bus_a.wb_stb_o, bus_a.wb_we_o});
      else n_pass++;
      if (i == 3) begin
        bus_a.wb_ack_i = 1'b1;
        bus_a.wb_dat_i = 32'hCAFE_BABE;
      end
      tick();
    end
    bus_a.wb_ack_i = 1'b0;
    n_total++;
    if ({a_valid, a_sdone, a_err, bus_a.wb_cyc_o} !== 4'b1000 || a_dl !== 32'hCAFE_BABE)
      $display("FAIL lw_resp got v/d/e/cyc=%b dl=%h exp 1000 cafebabe",
               {a_valid, a_sdone, a_err, bus_a.wb_cyc_o}, a_dl);
    else n_pass++;
    tick();
    n_total++;
    if ({a_valid, a_busy} !== 2'b00 || a_dl !== 32'hCAFE_BABE)
      $display("FAIL lw_hold got valid/busy=%b dl=%h exp 00 cafebabe", {a_valid, a_busy}, a_dl);
    else n_pass++;
  endtask

  task automatic test_misaligned;
    a_load = 1'b1; a_fun = 3'b001; a_addr = 32'h201;
    tick();
    a_load = 1'b0;
    n_total++;
    if ({bus_a.wb_cyc_o, a_valid, a_err} !== 3'b011 || a_dl !== 32'd0)
      $display("FAIL mis_resp got cyc/valid/err=%b dl=%h exp 011 00000000",
               {bus_a.wb_cyc_o, a_valid, a_err}, a_dl);
    else n_pass++;
    tick();
    n_total++;
    if ({a_valid, a_err, a_busy} !== 3'b000)
      $display("FAIL mis_idle got valid/err/busy=%b exp 000", {a_valid, a_err, a_busy});
    else n_pass++;
  endtask

  task automatic test_timeout;
    b_store = 1'b1; b_fun = 3'b010; b_addr = 32'h40; b_ds = 32'h1234_5678;
    tick();
    b_store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (bus_b.wb_stb_o !== 1'b1)
        $display("FAIL to_stb_cycle%0d got %b exp 1", i, bus_b.wb_stb_o);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({bus_b.wb_stb_o, b_sdone, b_err, b_valid} !== 4'b0110)
      $display("FAIL to_resp got stb/done/err/valid=%b exp 0110",
               {bus_b.wb_stb_o, b_sdone, b_err, b_valid});
    else n_pass++;
    tick();
    n_total++;
    if ({b_busy, b_sdone, b_err} !== 3'b000)
      $display("FAIL to_idle got busy/done/err=%b exp 000", {b_busy, b_sdone, b_err});
    else n_pass++;
  endtask

  task automatic test_priority_async_reset;
    a_load = 1'b1; a_store = 1'b1; a_fun = 3'b010; a_addr = 32'h300; a_ds = 32'h11;
    tick();
    a_load = 1'b0; a_store = 1'b0;
    n_total++;
    if ({bus_a.wb_cyc_o, bus_a.wb_we_o} !== 2'b11)
      $display("FAIL pri_store got cyc/we=%b exp 11", {bus_a.wb_cyc_o, bus_a.wb_we_o});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus_a.wb_cyc_o, bus_a.wb_stb_o, a_busy, bus_a.wb_we_o} !== 4'b0000 ||
        bus_a.wb_sel_o !== 4'd0 || bus_a.wb_adr_o !== 32'd0 || a_dl !== 32'd0)
      $display("FAIL arst_drop got cyc/stb/busy/we=%b sel=%b adr=%h dl=%h exp zeros",
               {bus_a.wb_cyc_o, bus_a.wb_stb_o, a_busy, bus_a.wb_we_o},
               bus_a.wb_sel_o, bus_a.wb_adr_o, a_dl);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    a_load = 1'b1; a_fun = 3'b010; a_addr = 32'h10;
    bus_a.wb_ack_i = 1'b1; bus_a.wb_err_i = 1'b1; bus_a.wb_dat_i = 32'hDEAD_BEEF;
    tick();
    tick();
    n_total++;
    if ({a_valid, a_err} !== 2'b11 || a_dl !== 32'd0)
      $display("FAIL b2b_err got valid/err=%b dl=%h exp 11 00000000", {a_valid, a_err}, a_dl);
    else n_pass++;
    a_addr = 32'h14; bus_a.wb_err_i = 1'b0; bus_a.wb_dat_i = 32'h1234_5678;
    tick();
    n_total++;
    if ({a_busy, a_valid} !== 2'b00)
      $display("FAIL b2b_idle got busy/valid=%b exp 00", {a_busy, a_valid});
    else n_pass++;
    tick();
    a_load = 1'b0;
    n_total++;
    if (bus_a.wb_cyc_o !== 1'b1 || bus_a.wb_adr_o !== 32'h14)
      $display("FAIL b2b_bus2 got cyc=%b adr=%h exp 1 00000014", bus_a.wb_cyc_o, bus_a.wb_adr_o);
    else n_pass++;
    tick();
    bus_a.wb_ack_i = 1'b0;
    n_total++;
    if ({a_valid, a_err} !== 2'b10 || a_dl !== 32'h1234_5678)
      $display("FAIL b2b_ok got valid/err=%b dl=%h exp 10 12345678", {a_valid, a_err}, a_dl);
    else n_pass++;
    tick();
    n_total++;
    if (a_busy !== 1'b0)
      $display("FAIL b2b_busy got %b exp 0", a_busy);
    else n_pass++;
  endtask

  initial begin
    a_load = 1'b0; a_store = 1'b0; a_fun = 3'b0; a_addr = 32'd0; a_ds = 32'd0;
    b_load = 1'b0; b_store = 1'b0; b_fun = 3'b0; b_addr = 32'd0; b_ds = 32'd0;
    bus_a.wb_ack_i = 1'b0; bus_a.wb_err_i = 1'b0; bus_a.wb_dat_i = 32'd0;
    bus_b.wb_ack_i = 1'b0; bus_b.wb_err_i = 1'b0; bus_b.wb_dat_i = 32'd0;
    test_reset();
    test_store_byte();
    test_store_half();
    test_load_wait();
    test_misaligned();
    test_timeout();
    test_priority_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
